// File: rtl/mem_pkg.sv
// Shared definitions for the byte-enable dual-port BRAM wrapper and its array core.
package mem_pkg;

  localparam int unsigned LaneBits = 8;
  // Upper bound on data width accepted by be_merge; callers cast to/from their width.
  localparam int unsigned MaxDbits = 1024;
  localparam int unsigned MaxNbe   = MaxDbits / LaneBits;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } bram_state_e;

  typedef logic [MaxDbits-1:0] word_t;
  typedef logic [MaxNbe-1:0]   lane_mask_t;

  function automatic word_t be_merge(word_t old_w, word_t new_w, lane_mask_t be);
    word_t res;
    res = old_w;
    for (int unsigned i = 0; i < MaxNbe; i++) begin
      if (be[i]) res[i*LaneBits +: LaneBits] = new_w[i*LaneBits +: LaneBits];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_dp_be_core.sv
// Behavioural two-port array with per-lane write enables and a registered raw read.
// No collision handling: a read returns the pre-edge contents.
module sram_dp_be_core
  import mem_pkg::*;
#(
  parameter int unsigned ABITS = 9,
  parameter int unsigned DBITS = 32,
  localparam int unsigned NBE  = DBITS / LaneBits
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [ABITS-1:0] i_a0,
  input  logic [DBITS-1:0] i_d0,
  input  logic [NBE-1:0]   i_we0,
  input  logic             i_re0,
  output logic [DBITS-1:0] o_q0,
  input  logic [ABITS-1:0] i_a1,
  input  logic [DBITS-1:0] i_d1,
  input  logic [NBE-1:0]   i_we1,
  input  logic             i_re1,
  output logic [DBITS-1:0] o_q1
);

  localparam int unsigned DEPTH = 2 ** ABITS;

  logic [DBITS-1:0] r_mem [DEPTH];
  logic [DBITS-1:0] r_q0;
  logic [DBITS-1:0] r_q1;

  // Port 1 lanes are applied last so they win on a same-address overlap.
  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < NBE; i++) begin
      if (i_we0[i]) r_mem[i_a0][i*LaneBits +: LaneBits] <= i_d0[i*LaneBits +: LaneBits];
    end
    for (int unsigned i = 0; i < NBE; i++) begin
      if (i_we1[i]) r_mem[i_a1][i*LaneBits +: LaneBits] <= i_d1[i*LaneBits +: LaneBits];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q0 <= '0;
      r_q1 <= '0;
    end else begin
      if (i_re0) r_q0 <= r_mem[i_a0];
      if (i_re1) r_q1 <= r_mem[i_a1];
    end
  end

  assign o_q0 = r_q0;
  assign o_q1 = r_q1;

endmodule

// File: rtl/bram_dp_be.sv
// True dual-port SRAM wrapper: byte enables, write-first forwarding, collision flag,
// optional output register and post-reset zero-fill sequencer.
module bram_dp_be
  import mem_pkg::*;
#(
  parameter int unsigned ABITS     = 9,
  parameter int unsigned DBITS     = 32,
  parameter int unsigned OUT_REG   = 0,
  parameter int unsigned INIT_ZERO = 1,
  localparam int unsigned NBE      = DBITS / LaneBits
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [ABITS-1:0] A0,
  input  logic [DBITS-1:0] D0,
  input  logic [NBE-1:0]   BE0,
  input  logic             WE0,
  input  logic             CE0,
  output logic [DBITS-1:0] Q0,
  input  logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] D1,
  input  logic [NBE-1:0]   BE1,
  input  logic             WE1,
  input  logic             CE1,
  output logic [DBITS-1:0] Q1,
  output logic             RDY,
  output logic             COLL
);

  bram_state_e      r_state, w_state_d;
  logic [ABITS-1:0] r_cnt, w_cnt_d;
  logic             w_rdy, w_init_wr;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StInit: begin
        w_cnt_d = r_cnt + ABITS'(1);
        if (INIT_ZERO == 0 || r_cnt == '1) w_state_d = StRun;
      end
      StRun: ;
    endcase
  end

  always_comb begin
    w_rdy     = (r_state == StRun);
    w_init_wr = (r_state == StInit) && (INIT_ZERO != 0);
  end

  // Access qualification: nothing from the tile reaches the array until ready.
  logic w_ce0, w_ce1, w_wr0, w_wr1, w_re0, w_re1;
  assign w_ce0 = CE0 && w_rdy;
  assign w_ce1 = CE1 && w_rdy;
  assign w_wr0 = w_ce0 && WE0;
  assign w_wr1 = w_ce1 && WE1;
  assign w_re0 = w_ce0 && !WE0;
  assign w_re1 = w_ce1 && !WE1;

  logic             w_same_addr;
  assign w_same_addr = (A0 == A1);

  logic [ABITS-1:0] w_p0_addr;
  logic [DBITS-1:0] w_p0_wdata;
  logic [NBE-1:0]   w_p0_we, w_p1_we;

  always_comb begin
    w_p0_addr  = w_init_wr ? r_cnt : A0;
    w_p0_wdata = w_init_wr ? '0 : D0;
    w_p0_we    = w_init_wr ? '1 : (w_wr0 ? BE0 : '0);
    w_p1_we    = w_wr1 ? BE1 : '0;
  end

  logic [DBITS-1:0] w_core_q0, w_core_q1;

  sram_dp_be_core #(
    .ABITS (ABITS),
    .DBITS (DBITS)
  ) u_core (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_a0    (w_p0_addr),
    .i_d0    (w_p0_wdata),
    .i_we0   (w_p0_we),
    .i_re0   (w_re0),
    .o_q0    (w_core_q0),
    .i_a1    (A1),
    .i_d1    (D1),
    .i_we1   (w_p1_we),
    .i_re1   (w_re1),
    .o_q1    (w_core_q1)
  );

  // Lanes the opposite port wrote to the read address in the read cycle; they are
  // overlaid on the raw array word so reads see write-first data.
  logic [DBITS-1:0] r_fwd0_d, r_fwd1_d;
  logic [NBE-1:0]   r_fwd0_be, r_fwd1_be;
  logic             r_coll;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_fwd0_d  <= '0;
      r_fwd0_be <= '0;
      r_fwd1_d  <= '0;
      r_fwd1_be <= '0;
      r_coll    <= 1'b0;
    end else begin
      if (w_re0) begin
        r_fwd0_d  <= D1;
        r_fwd0_be <= (w_wr1 && w_same_addr) ? BE1 : '0;
      end
      if (w_re1) begin
        r_fwd1_d  <= D0;
        r_fwd1_be <= (w_wr0 && w_same_addr) ? BE0 : '0;
      end
      r_coll <= w_wr0 && w_wr1 && w_same_addr && (|BE0) && (|BE1);
    end
  end

  logic [DBITS-1:0] w_rd0, w_rd1;
  assign w_rd0 = DBITS'(be_merge(word_t'(w_core_q0), word_t'(r_fwd0_d), lane_mask_t'(r_fwd0_be)));
  assign w_rd1 = DBITS'(be_merge(word_t'(w_core_q1), word_t'(r_fwd1_d), lane_mask_t'(r_fwd1_be)));

  if (OUT_REG != 0) begin : g_out_reg
    logic             r_rd0_vld, r_rd1_vld;
    logic [DBITS-1:0] r_oq0, r_oq1;

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        r_rd0_vld <= 1'b0;
        r_rd1_vld <= 1'b0;
        r_oq0     <= '0;
        r_oq1     <= '0;
      end else begin
        r_rd0_vld <= w_re0;
        r_rd1_vld <= w_re1;
        if (r_rd0_vld) r_oq0 <= w_rd0;
        if (r_rd1_vld) r_oq1 <= w_rd1;
      end
    end

    assign Q0 = r_oq0;
    assign Q1 = r_oq1;
  end else begin : g_no_out_reg
    assign Q0 = w_rd0;
    assign Q1 = w_rd1;
  end

  assign RDY  = w_rdy;
  assign COLL = r_coll;

endmodule

// File: tb/tb_bram_dp_be.sv
// Directed bench for bram_dp_be: one instance without and one with the output register,
// driven by identical stimulus.
module tb_bram_dp_be;

  localparam int unsigned AB = 4;
  localparam int unsigned DB = 32;
  localparam int unsigned NB = 4;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic [AB-1:0] a0, a1;
  logic [DB-1:0] d0, d1;
  logic [NB-1:0] be0, be1;
  logic          we0, we1, ce0, ce1;
  logic [DB-1:0] q0_a, q1_a, q0_b, q1_b;
  logic          rdy_a, rdy_b, coll_a, coll_b;

  always #5 clk = ~clk;

  bram_dp_be #(.ABITS(AB), .DBITS(DB), .OUT_REG(0), .INIT_ZERO(1)) u_dut_a (
    .CLK(clk), .RSTN(rstn),
    .A0(a0), .D0(d0), .BE0(be0), .WE0(we0), .CE0(ce0), .Q0(q0_a),
    .A1(a1), .D1(d1), .BE1(be1), .WE1(we1), .CE1(ce1), .Q1(q1_a),
    .RDY(rdy_a), .COLL(coll_a)
  );

  bram_dp_be #(.ABITS(AB), .DBITS(DB), .OUT_REG(1), .INIT_ZERO(1)) u_dut_b (
    .CLK(clk), .RSTN(rstn),
    .A0(a0), .D0(d0), .BE0(be0), .WE0(we0), .CE0(ce0), .Q0(q0_b),
    .A1(a1), .D1(d1), .BE1(be1), .WE1(we1), .CE1(ce1), .Q1(q1_b),
    .RDY(rdy_b), .COLL(coll_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          ce0, we0;
    logic [AB-1:0] a0;
    logic [DB-1:0] d0;
    logic [NB-1:0] be0;
    logic          ce1, we1;
    logic [AB-1:0] a1;
    logic [DB-1:0] d1;
    logic [NB-1:0] be1;
    logic [DB-1:0] q0, q1;
    logic          coll;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b0; we1 = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (n < 40 && !rdy_a) begin
      tick;
      n++;
      if (!rdy_a && (q0_a !== 0 || q1_a !== 0 || q0_b !== 0 || q1_b !== 0 ||
                     coll_a !== 1'b0 || rdy_b !== 1'b0)) bad++;
    end
    chk({name, " rdy cycles"}, n, 16);
    chk({name, " quiet during init"}, bad, 0);
    chk({name, " rdy outreg dut"}, 32'(rdy_b), 1);
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      a0 = AB'(i); ce0 = 1'b1; we0 = 1'b0;
      tick;
      chk($sformatf("%s zero q0 a%0d", name, i), q0_a, 0);
      ce0 = 1'b0;
      tick;
      chk($sformatf("%s zero q0 outreg a%0d", name, i), q0_b, 0);
    end
  endtask

  initial begin
    logic [DB-1:0] prev_q0, prev_q1;
    idle;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; be0 = '0; be1 = '0;

    //                ce0  we0  a0  d0            be0   ce1  we1  a1  d1            be1   q0            q1            coll
    vecs[0]  = '{1'b1, 1'b1, 4'd3, 32'h11223344, 4'hF, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0,
                 32'h0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'h5, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0,
                 32'h0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0,
                 32'h0, 32'h11BB33DD, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'd5, 32'h11111111, 4'hF, 1'b1, 1'b1, 4'd5, 32'h22222222, 4'h3,
                 32'h0, 32'h11BB33DD, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0,
                 32'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'd5, 32'h0, 4'h0, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0,
                 32'h11112222, 32'h11112222, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'd7, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0,
                 32'h11112222, 32'h11112222, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'd7, 32'h0, 4'hF, 1'b1, 1'b1, 4'd7, 32'h00000055, 4'h1,
                 32'hDEADBE55, 32'h11112222, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 1'b0, 4'd7, 32'h0, 4'h0,
                 32'hDEADBE55, 32'hDEADBE55, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 4'd7, 32'hA5A5A5A5, 4'hA, 1'b1, 1'b0, 4'd7, 32'h0, 4'hF,
                 32'hDEADBE55, 32'hA5ADA555, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'd9, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b1, 4'd9, 32'h12345678, 4'hF,
                 32'hDEADBE55, 32'hA5ADA555, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'd9, 32'h0, 4'h0, 1'b1, 1'b0, 4'd7, 32'h0, 4'h0,
                 32'h12345678, 32'hA5ADA555, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'd4, 32'hAAAAAAAA, 4'hC, 1'b1, 1'b1, 4'd4, 32'hBBBBBBBB, 4'h3,
                 32'h12345678, 32'hA5ADA555, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 1'b1, 1'b0, 4'd4, 32'h0, 4'h0,
                 32'hAAAABBBB, 32'hAAAABBBB, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 4'd0, 32'h01020304, 4'hF, 1'b1, 1'b1, 4'd15, 32'h0A0B0C0D, 4'hF,
                 32'hAAAABBBB, 32'hAAAABBBB, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'd15, 32'h0, 4'h0, 1'b1, 1'b0, 4'd0, 32'h0, 4'h0,
                 32'h0A0B0C0D, 32'h01020304, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 4'd15, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0,
                 32'h0A0B0C0D, 32'h01020304, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 4'd15, 32'h0, 4'h0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0,
                 32'h0A0B0C0D, 32'h01020304, 1'b0};

    #22;
    chk("reset q0", q0_a, 0);
    chk("reset q1", q1_a, 0);
    chk("reset rdy", 32'(rdy_a), 0);
    chk("reset coll", 32'(coll_a), 0);
    chk("reset q0 outreg", q0_b, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_ready("init");
    read_all_zero("init");

    prev_q0 = '0;
    prev_q1 = '0;
    for (int k = 0; k < 18; k++) begin
      ce0 = vecs[k].ce0; we0 = vecs[k].we0; a0 = vecs[k].a0; d0 = vecs[k].d0; be0 = vecs[k].be0;
      ce1 = vecs[k].ce1; we1 = vecs[k].we1; a1 = vecs[k].a1; d1 = vecs[k].d1; be1 = vecs[k].be1;
      tick;
      chk($sformatf("vec%0d q0", k), q0_a, vecs[k].q0);
      chk($sformatf("vec%0d q1", k), q1_a, vecs[k].q1);
      chk($sformatf("vec%0d coll", k), 32'(coll_a), 32'(vecs[k].coll));
      chk($sformatf("vec%0d coll outreg", k), 32'(coll_b), 32'(vecs[k].coll));
      chk($sformatf("vec%0d q0 outreg", k), q0_b, prev_q0);
      chk($sformatf("vec%0d q1 outreg", k), q1_b, prev_q1);
      prev_q0 = vecs[k].q0;
      prev_q1 = vecs[k].q1;
    end
    idle;
    tick;
    chk("tail q0 outreg", q0_b, prev_q0);
    chk("tail q1 outreg", q1_b, prev_q1);

    // Read, then hold CE0 low while address and data wiggle.
    ce0 = 1'b1; we0 = 1'b1; a0 = 4'd2; d0 = 32'hCAFEF00D; be0 = 4'hF;
    tick;
    we0 = 1'b0;
    tick;
    chk("hold read q0", q0_a, 32'hCAFEF00D);
    ce0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a0 = AB'(i * 3 + 1);
      d0 = $urandom;
      we0 = i[0];
      tick;
      chk($sformatf("hold%0d q0", i), q0_a, 32'hCAFEF00D);
      chk($sformatf("hold%0d q0 outreg", i), q0_b, 32'hCAFEF00D);
    end
    idle;

    // Asynchronous clear from RUN, then a reset in the middle of the zero-fill.
    #3;
    rstn = 1'b0;
    #1;
    chk("async clr q0", q0_a, 0);
    chk("async clr q0 outreg", q0_b, 0);
    chk("async clr q1", q1_a, 0);
    chk("async clr rdy", 32'(rdy_a), 0);
    tick;
    rstn = 1'b1;
    repeat (8) tick;
    chk("mid-init rdy", 32'(rdy_a), 0);
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    wait_ready("reinit");
    read_all_zero("reinit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_dp_be.md
Name: bram_dp_be

Overview:
Parametrised true dual-port on-chip SRAM wrapper. It is the successor to the fixed 512x32 BRAM wrappers and is used by accelerator PLMs and cache data arrays.
Adds byte-enable writes, deterministic same-address collision and read-during-write forwarding, an optional output register, and a post-reset zero-initialisation sequencer with a ready flag.
Sits between the tile logic and the technology macro or behavioural array.

Parameters:
ABITS, 9, address width; depth = 2**ABITS
DBITS, 32, data width; must be a multiple of 8
NBE, DBITS/8, byte lanes (derived; not overridable)
OUT_REG, 0, 1 = extra output pipeline register on Q0/Q1
INIT_ZERO, 1, 1 = clear the whole array after reset before accepting traffic

Ports:
CLK  in  1  clock; all state updates on rising edge
RSTN  in  1  asynchronous active-low reset
A0  in  ABITS  port 0 address
D0  in  DBITS  port 0 write data
BE0  in  NBE  port 0 byte enables (write only)
WE0  in  1  port 0 write when CE0=1
CE0  in  1  port 0 access enable
Q0  out  DBITS  port 0 read data
A1, D1, BE1, WE1, CE1, Q1  same widths and meanings for port 1
RDY  out  1  1 = array accepting accesses
COLL  out  1  one-cycle pulse: both ports wrote the same address

Behaviour:
- Reset (RSTN=0, async): Q0=Q1=0, RDY=0, COLL=0, output regs=0, FSM=INIT, init counter=0. Array contents are not reset directly.
- FSM states:
  - INIT: one write per cycle of all-zero data at address cnt, all lanes enabled. cnt++ each cycle. When cnt = 2**ABITS-1 is written, go to RUN, with RDY=1 on the next cycle. Total 2**ABITS cycles from reset release.
  - INIT_ZERO=0: INIT lasts exactly one cycle with no writes.
  - RUN: terminal until reset.
  - Reset asserted mid-INIT restarts from cnt=0.
- While RDY=0: CE0/CE1 are ignored, Q holds 0, COLL=0.
- Write (CEp=1, WEp=1): byte lane i of mem[Ap] takes Dp[8i+7:8i] iff BEp[i]=1. Other lanes are unchanged. BEp=0 is a no-op. Qp is unchanged on a write cycle.
- Read (CEp=1, WEp=0): Qp = mem[Ap] after 1 edge (OUT_REG=0) or 2 edges (OUT_REG=1). BEp is ignored.
- Idle (CEp=0): Qp holds its last value.
- Write/write same address, same cycle:
  - Lanes enabled on both ports take D1 (port 1 wins).
  - Lanes enabled on one port only take that port's data.
  - COLL=1 on the following cycle only, regardless of BE overlap, provided both BE are nonzero.
- Read on port x, write on port y, same address, same cycle: write-first.
  - Qx returns the post-write word: written lanes from Dy, other lanes from the old contents.
  - Forwarding is done in the wrapper. The macro's collision behaviour is never relied on.
- Reads on both ports to the same address: both return the same word. No COLL.
- Address wrap: none; addresses are used modulo depth by construction.
- With OUT_REG=1, the pipeline register updates only when the read-stage register updates, so Q timing is a pure 1-cycle delay of the OUT_REG=0 behaviour.

Decomposition:
- Shared package (mem_pkg): byte-lane width constant 8, FSM state enum (INIT, RUN), a byte-mask merge function (old, new, be) -> word.
- One sub-module: sram_dp_be_core. This is a behavioural/techmapped 2-port array with per-lane write enables and a registered raw read, no forwarding.
- The wrapper owns the FSM, init mux onto port 0, collision/forwarding compare, and output registers.

Test Plan:
- Reset, ABITS=4, INIT_ZERO=1 -> RDY rises exactly 16 cycles after RSTN release. Reading all 16 addresses returns 0x00000000. Q0=Q1=0 throughout init.
- Write A0=3, D0=0xAABBCCDD, BE0=0b0101, over prior contents 0x11223344 -> read A1=3 returns 0x11BB33DD, one cycle later (OUT_REG=0) or two cycles later (OUT_REG=1).
- Same cycle: port 0 writes addr 5 D0=0x11111111 BE0=0xF; port 1 writes addr 5 D1=0x22222222 BE1=0x3 -> mem[5]=0x11112222, COLL=1 for exactly one cycle.
- Same cycle: port 0 reads addr 7 (old 0xDEADBEEF); port 1 writes addr 7 D1=0x00000055 BE1=0x1 -> Q0=0xDEADBE55.
- Read addr 2 then hold CE0=0 for 5 cycles -> Q0 stable. Toggle A0 while CE0=0 -> no change.
- Assert RSTN=0 at init cycle 8, release -> RDY again 16 cycles after release, Q cleared asynchronously, array fully zero.
